// File: rtl/mem_portb_arbiter_if.sv
// rtl/mem_portb_arbiter_if.sv - CPU/loader request buses and memory port B pins shared by the arbiter
interface mem_portb_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_gnt;
    logic              cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;

    logic              ld_req;
    logic              ld_we;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_wdata;
    logic              ld_done;
    logic              ld_gnt;
    logic              ld_rvalid;
    logic [DATA_W-1:0] ld_rdata;

    logic              boot_active;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    // arbiter side
    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_gnt, cpu_rvalid, cpu_rdata,
        input  ld_req, ld_we, ld_addr, ld_wdata, ld_done,
        output ld_gnt, ld_rvalid, ld_rdata,
        output boot_active,
        output mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    // requesters and memory side
    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_gnt, cpu_rvalid, cpu_rdata,
        output ld_req, ld_we, ld_addr, ld_wdata, ld_done,
        input  ld_gnt, ld_rvalid, ld_rdata,
        input  boot_active,
        input  mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/mem_portb_arbiter.sv
// rtl/mem_portb_arbiter.sv - data memory port B arbiter: loader-only BOOT phase, then CPU/loader RUN arbitration
// Optional MEM_ARB_RR_EN: round-robin conflict resolution instead of CPU priority with starvation guard.
module mem_portb_arbiter #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 8,
    parameter int MAX_WAIT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    mem_portb_arbiter_if.slave   bus
);
    typedef enum logic {ST_BOOT, ST_RUN} state_t;

    state_t            state, state_nxt;
    logic              cpu_arb, ld_arb;
    logic              cpu_sel, ld_sel;
    logic              conflict;
    logic              rd_cpu, rd_ld;
    logic [DATA_W-1:0] cpu_rdata_q, ld_rdata_q;
    logic [ADDR_W-1:0] last_addr;
    logic [DATA_W-1:0] last_wdata;

`ifdef MEM_ARB_RR_EN
    logic last_cpu;
`else
    localparam logic [3:0] MAX_W = 4'(MAX_WAIT);
    logic [3:0] wait_cnt, wait_nxt;
`endif

    assign conflict = (state == ST_RUN) && bus.cpu_req && bus.ld_req;

    always_comb begin
        state_nxt = state;
        cpu_arb   = 1'b0;
        ld_arb    = 1'b0;
        case (state)
            ST_BOOT: begin
                ld_arb = bus.ld_req;
                if (bus.ld_done)
                    state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (conflict) begin
`ifdef MEM_ARB_RR_EN
                    cpu_arb = !last_cpu;
`else
                    cpu_arb = (wait_cnt != MAX_W);
`endif
                    ld_arb  = !cpu_arb;
                end else begin
                    cpu_arb = bus.cpu_req;
                    ld_arb  = bus.ld_req;
                end
            end
            default: state_nxt = ST_BOOT;
        endcase
    end

    // Grants are forced low while reset is asserted, even though they are combinational.
    assign cpu_sel = cpu_arb & rst;
    assign ld_sel  = ld_arb & rst;

    always_comb begin
        bus.mem_we    = 1'b0;
        bus.mem_addr  = last_addr;
        bus.mem_wdata = last_wdata;
        if (cpu_sel) begin
            bus.mem_we    = bus.cpu_we;
            bus.mem_addr  = bus.cpu_addr;
            bus.mem_wdata = bus.cpu_wdata;
        end else if (ld_sel) begin
            bus.mem_we    = bus.ld_we;
            bus.mem_addr  = bus.ld_addr;
            bus.mem_wdata = bus.ld_wdata;
        end
    end

`ifndef MEM_ARB_RR_EN
    always_comb begin
        wait_nxt = 4'd0;
        if ((state == ST_RUN) && bus.ld_req && !ld_sel)
            wait_nxt = (wait_cnt == MAX_W) ? wait_cnt : wait_cnt + 4'd1;
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_BOOT;
            rd_cpu      <= 1'b0;
            rd_ld       <= 1'b0;
            cpu_rdata_q <= '0;
            ld_rdata_q  <= '0;
            last_addr   <= '0;
            last_wdata  <= '0;
`ifdef MEM_ARB_RR_EN
            last_cpu    <= 1'b0;
`else
            wait_cnt    <= 4'd0;
`endif
        end else begin
            state      <= state_nxt;
            rd_cpu     <= cpu_sel && !bus.cpu_we;
            rd_ld      <= ld_sel && !bus.ld_we;
            last_addr  <= bus.mem_addr;
            last_wdata <= bus.mem_wdata;
            if (rd_cpu)
                cpu_rdata_q <= bus.mem_rdata;
            if (rd_ld)
                ld_rdata_q <= bus.mem_rdata;
`ifdef MEM_ARB_RR_EN
            if (conflict)
                last_cpu <= cpu_sel;
`else
            wait_cnt <= wait_nxt;
`endif
        end
    end

    assign bus.cpu_gnt     = cpu_sel;
    assign bus.ld_gnt      = ld_sel;
    assign bus.cpu_rvalid  = rd_cpu;
    assign bus.ld_rvalid   = rd_ld;
    assign bus.cpu_rdata   = rd_cpu ? bus.mem_rdata : cpu_rdata_q;
    assign bus.ld_rdata    = rd_ld ? bus.mem_rdata : ld_rdata_q;
    assign bus.boot_active = (state == ST_BOOT);
endmodule

// File: tb/tb_mem_portb_arbiter.sv
// tb/tb_mem_portb_arbiter.sv - directed table-driven bench for mem_portb_arbiter with a 256x8 sync-read memory
module tb_mem_portb_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    mem_portb_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus ();

    mem_portb_arbiter #(.ADDR_W(8), .DATA_W(8), .MAX_WAIT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [7:0] mem [256];
    always @(posedge clk) begin
        if (bus.mem_we)
            mem[bus.mem_addr] <= bus.mem_wdata;
        bus.mem_rdata <= mem[bus.mem_addr];
    end

    typedef struct {
        logic       cr, cw;
        logic [7:0] ca, cd;
        logic       lr, lw;
        logic [7:0] la, lwd;
        logic       done;
        logic [37:0] exp;
    } vec_t;

    function automatic vec_t mk(
        input logic cr, input logic cw, input logic [7:0] ca, input logic [7:0] cd,
        input logic lr, input logic lw, input logic [7:0] la, input logic [7:0] lwd, input logic done,
        input logic cg, input logic lg, input logic mwe, input logic [7:0] maddr, input logic [7:0] mwd,
        input logic boot, input logic crv, input logic [7:0] crd, input logic lrv, input logic [7:0] lrd);
        vec_t v;
        v.cr = cr; v.cw = cw; v.ca = ca; v.cd = cd;
        v.lr = lr; v.lw = lw; v.la = la; v.lwd = lwd; v.done = done;
        v.exp = {cg, lg, mwe, maddr, mwd, boot, crv, crd, lrv, lrd};
        return v;
    endfunction

    function automatic logic [37:0] observe();
        return {bus.cpu_gnt, bus.ld_gnt, bus.mem_we, bus.mem_addr, bus.mem_wdata,
                bus.boot_active, bus.cpu_rvalid, bus.cpu_rdata, bus.ld_rvalid, bus.ld_rdata};
    endfunction

    task automatic drive(input vec_t v);
        bus.cpu_req = v.cr; bus.cpu_we = v.cw; bus.cpu_addr = v.ca; bus.cpu_wdata = v.cd;
        bus.ld_req = v.lr; bus.ld_we = v.lw; bus.ld_addr = v.la; bus.ld_wdata = v.lwd;
        bus.ld_done = v.done;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    vec_t       tbl [12];
    logic [5:0] cg_pat;
    logic       prev_lg;
    logic [7:0] lrd_exp;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h01] = 8'h11;
        mem[8'h02] = 8'h22;
        bus.mem_rdata = 8'h00;

        //        cr cw ca     cd     lr lw la     lwd    dn  cg lg we addr   wd     bt crv crd    lrv lrd
        tbl[0]  = mk(1, 0, 8'h10, 8'h00, 1, 1, 8'h10, 8'hA5, 0, 0, 1, 1, 8'h10, 8'hA5, 1, 0, 8'h00, 0, 8'h00);
        tbl[1]  = mk(1, 0, 8'h10, 8'h00, 1, 1, 8'h20, 8'h33, 1, 0, 1, 1, 8'h20, 8'h33, 1, 0, 8'h00, 0, 8'h00);
        tbl[2]  = mk(1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00, 0, 1, 0, 0, 8'h10, 8'h00, 0, 0, 8'h00, 0, 8'h00);
        tbl[3]  = mk(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 8'h10, 8'h00, 0, 1, 8'hA5, 0, 8'h00);
        tbl[4]  = mk(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 8'h10, 8'h00, 0, 0, 8'hA5, 0, 8'h00);
        tbl[5]  = mk(1, 0, 8'h01, 8'h00, 0, 0, 8'h00, 8'h00, 0, 1, 0, 0, 8'h01, 8'h00, 0, 0, 8'hA5, 0, 8'h00);
        tbl[6]  = mk(0, 0, 8'h00, 8'h00, 1, 0, 8'h02, 8'h00, 0, 0, 1, 0, 8'h02, 8'h00, 0, 1, 8'h11, 0, 8'h00);
        tbl[7]  = mk(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 8'h02, 8'h00, 0, 0, 8'h11, 1, 8'h22);
        tbl[8]  = mk(0, 0, 8'h00, 8'h00, 1, 1, 8'h40, 8'h77, 0, 0, 1, 1, 8'h40, 8'h77, 0, 0, 8'h11, 0, 8'h22);
        tbl[9]  = mk(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 8'h40, 8'h77, 0, 0, 8'h11, 0, 8'h22);
        tbl[10] = mk(1, 0, 8'h40, 8'h00, 0, 0, 8'h00, 8'h00, 0, 1, 0, 0, 8'h40, 8'h00, 0, 0, 8'h11, 0, 8'h22);
        tbl[11] = mk(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 8'h40, 8'h00, 0, 1, 8'h77, 0, 8'h22);

        // Reset held with both requests high: nothing may be granted or written.
        drive(mk(1, 1, 8'h55, 8'h66, 1, 1, 8'h77, 8'h88, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        check("reset_state", 64'(observe()), 64'({1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00}));

        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            rst = 1'b1;
            drive(tbl[i]);
            @(negedge clk);
            check($sformatf("vec%0d", i), 64'(observe()), 64'(tbl[i].exp));
        end

        // Continuous conflict: CPU writes 0x55 to 0x30, loader reads 0x20 (holds 0x33).
`ifdef MEM_ARB_RR_EN
        cg_pat = 6'b010101;
`else
        cg_pat = 6'b101111;
`endif
        prev_lg = 1'b0;
        lrd_exp = 8'h22;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            drive(mk(1, 1, 8'h30, 8'h55, 1, 0, 8'h20, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
            @(negedge clk);
            if (prev_lg) lrd_exp = 8'h33;
            check($sformatf("conflict%0d", k),
                  64'({bus.cpu_gnt, bus.ld_gnt, bus.mem_we, bus.mem_addr, bus.ld_rvalid, bus.ld_rdata}),
                  64'({cg_pat[k], !cg_pat[k], cg_pat[k], cg_pat[k] ? 8'h30 : 8'h20, prev_lg, lrd_exp}));
            prev_lg = !cg_pat[k];
        end

        // Reset in the cycle after a granted CPU read drops the pending rvalid.
        @(posedge clk); #1;
        drive(mk(1, 0, 8'h01, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        check("pre_reset_read_gnt", 64'(bus.cpu_gnt), 64'(1));
        @(posedge clk); #1;
        rst = 1'b0;
        drive(mk(0, 0, 8'h00, 8'h00, 1, 1, 8'h99, 8'h42, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        #1;
        check("mid_reset", 64'({bus.cpu_rvalid, bus.boot_active, bus.mem_we, bus.mem_addr, bus.ld_gnt, bus.cpu_gnt}),
              64'({1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0}));
        @(posedge clk); #1;
        rst = 1'b1;
        drive(mk(1, 0, 8'h01, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        check("reboot_cpu_stalled", 64'({bus.cpu_gnt, bus.boot_active, bus.cpu_rvalid}), 64'({1'b0, 1'b1, 1'b0}));
        @(posedge clk); #1;
        drive(mk(1, 0, 8'h01, 8'h00, 1, 1, 8'h05, 8'h5A, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        check("reboot_loader_gnt", 64'({bus.ld_gnt, bus.cpu_gnt, bus.mem_we, bus.mem_addr, bus.mem_wdata}),
              64'({1'b1, 1'b0, 1'b1, 8'h05, 8'h5A}));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
